// File: rtl/display_scheduler.sv
// Display bus arbiter: grants the six-digit BCD bus to the scrolling banner,
// the live timer count, or a held result, and paces banner scroll and hold time.
module display_scheduler #(
    parameter int TICK_DIV    = 25_000_000,
    parameter int BANNER_PASS = 2,
    parameter int HOLD_TICKS  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        banner_start,
    input  logic [23:0] banner_bcd,
    input  logic        timer_req,
    input  logic [23:0] timer_bcd,
    input  logic        res_valid,
    input  logic [23:0] res_bcd,
    output logic [3:0]  scroll_pos,
    output logic        scroll_step,
    output logic [23:0] bcd_out,
    output logic [1:0]  src,
    output logic        banner_done
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BANNER = 2'd1;
    localparam logic [1:0] ST_TIMER  = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(BANNER_PASS + 1);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] PASS_LAST  = SW'(BANNER_PASS);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_TICKS);

    logic [1:0]    state_reg, state_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic [3:0]    pos_reg, pos_next;
    logic [SW-1:0] pass_reg, pass_next;
    logic [HW-1:0] hold_reg, hold_next;
    logic [23:0]   latch_reg, latch_next;
    logic [SW-1:0] pass_inc;
    logic [HW-1:0] hold_inc;
    logic          tick;
    logic          done_now;
    logic          restart;

    assign tick     = ((state_reg == ST_BANNER) || (state_reg == ST_HOLD)) && (presc_reg == PRESC_LAST);
    assign pass_inc = pass_reg + SW'(1);
    assign hold_inc = hold_reg + HW'(1);

    always_comb begin
        state_next = state_reg;
        pos_next   = pos_reg;
        pass_next  = pass_reg;
        hold_next  = hold_reg;
        latch_next = latch_reg;
        presc_next = presc_reg;
        done_now   = 1'b0;
        restart    = 1'b0;

        if (res_valid) begin
            state_next = ST_HOLD;
            latch_next = res_bcd;
            hold_next  = '0;
            restart    = 1'b1;
        end else if (timer_req && (state_reg != ST_HOLD)) begin
            state_next = ST_TIMER;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (banner_start) state_next = ST_BANNER;
                end
                ST_BANNER: begin
                    if (tick) begin
                        pos_next = pos_reg + 4'd1;
                        if (pos_reg == 4'd15) begin
                            pass_next = pass_inc;
                            if (pass_inc == PASS_LAST) begin
                                state_next = ST_IDLE;
                                done_now   = 1'b1;
                            end
                        end
                    end
                end
                ST_TIMER: begin
                    // Reaching here means timer_req has dropped.
                    state_next = ST_IDLE;
                end
                default: begin
                    if (tick) begin
                        hold_next = hold_inc;
                        if (hold_inc == HOLD_LAST) state_next = timer_req ? ST_TIMER : ST_IDLE;
                    end
                end
            endcase
        end

        if (state_next != state_reg) restart = 1'b1;

        // A banner that is left, for any reason, starts over from frame 0.
        if ((state_next != ST_BANNER) || (state_reg != ST_BANNER)) begin
            pos_next  = '0;
            pass_next = '0;
        end
        if (state_next != ST_HOLD) hold_next = '0;

        if (restart || tick) begin
            presc_next = '0;
        end else if ((state_reg == ST_BANNER) || (state_reg == ST_HOLD)) begin
            presc_next = presc_reg + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            presc_reg <= '0;
            pos_reg   <= '0;
            pass_reg  <= '0;
            hold_reg  <= '0;
            latch_reg <= '0;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            pos_reg   <= pos_next;
            pass_reg  <= pass_next;
            hold_reg  <= hold_next;
            latch_reg <= latch_next;
        end
    end

    // Output digits follow the owner of the previous cycle; blank code is 15.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_digit
            logic [3:0] digit_reg;
            logic [3:0] digit_next;

            assign digit_next = (state_reg == ST_BANNER) ? banner_bcd[gi*4 +: 4] :
                                (state_reg == ST_TIMER)  ? timer_bcd[gi*4 +: 4]  :
                                (state_reg == ST_HOLD)   ? latch_reg[gi*4 +: 4]  : 4'hF;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) digit_reg <= 4'hF;
                else        digit_reg <= digit_next;
            end

            assign bcd_out[gi*4 +: 4] = digit_reg;
        end
    endgenerate

    assign scroll_pos  = pos_reg;
    assign scroll_step = tick;
    assign src         = state_reg;
    assign banner_done = done_now;

endmodule

// File: tb/tb_display_scheduler.sv
// Self-checking bench for display_scheduler: directed scenarios plus random
// traffic against an age-based reference model of display ownership.
module tb_display_scheduler;

    localparam int TD = 4;
    localparam int BP = 1;
    localparam int HT = 2;

    logic        clk;
    logic        rst_n;
    logic        banner_start;
    logic [23:0] banner_bcd;
    logic        timer_req;
    logic [23:0] timer_bcd;
    logic        res_valid;
    logic [23:0] res_bcd;
    logic [3:0]  scroll_pos;
    logic        scroll_step;
    logic [23:0] bcd_out;
    logic [1:0]  src;
    logic        banner_done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owner plus cycles spent with that owner since entry.
    int          m_src;
    int          m_age;
    logic [23:0] m_bcd;
    logic [23:0] m_latch;
    logic        e_step;
    logic        e_done;
    logic [3:0]  e_pos;

    display_scheduler #(.TICK_DIV(TD), .BANNER_PASS(BP), .HOLD_TICKS(HT)) dut (
        .clk(clk), .rst_n(rst_n),
        .banner_start(banner_start), .banner_bcd(banner_bcd),
        .timer_req(timer_req), .timer_bcd(timer_bcd),
        .res_valid(res_valid), .res_bcd(res_bcd),
        .scroll_pos(scroll_pos), .scroll_step(scroll_step),
        .bcd_out(bcd_out), .src(src), .banner_done(banner_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic m_reset();
        m_src   = 0;
        m_age   = 0;
        m_bcd   = 24'hFFFFFF;
        m_latch = '0;
    endtask

    task automatic m_comb();
        int steps;
        steps  = m_age / TD;
        e_step = ((m_src == 1) || (m_src == 3)) && ((m_age % TD) == TD - 1);
        e_pos  = (m_src == 1) ? 4'(steps % 16) : 4'd0;
        e_done = (m_src == 1) && e_step && (steps + 1 == 16 * BP) && !res_valid && !timer_req;
    endtask

    task automatic m_edge();
        int nsrc;
        bit restart;
        m_comb();
        case (m_src)
            1:       m_bcd = banner_bcd;
            2:       m_bcd = timer_bcd;
            3:       m_bcd = m_latch;
            default: m_bcd = 24'hFFFFFF;
        endcase
        nsrc    = m_src;
        restart = 1'b0;
        if (res_valid) begin
            nsrc    = 3;
            restart = 1'b1;
            m_latch = res_bcd;
        end else if (timer_req && m_src != 3) nsrc = 2;
        else if (m_src == 0 && banner_start) nsrc = 1;
        else if (m_src == 1 && e_done) nsrc = 0;
        else if (m_src == 2) nsrc = 0;
        else if (m_src == 3 && e_step && (m_age / TD + 1 == HT)) nsrc = timer_req ? 2 : 0;
        m_age = (restart || nsrc != m_src) ? 0 : m_age + 1;
        m_src = nsrc;
    endtask

    // Advance one clock: model follows the edge, new random datapath digits follow.
    task automatic cyc();
        @(posedge clk);
        m_edge();
        #2;
        m_comb();
        banner_bcd = 24'($urandom);
        timer_bcd  = 24'($urandom);
    endtask

    task automatic clear_inputs();
        banner_start = 1'b0;
        timer_req    = 1'b0;
        res_valid    = 1'b0;
        res_bcd      = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        m_reset();
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_checks++;
            if (bcd_out !== 24'hFFFFFF) begin n_errors++; $display("FAIL reset_bcd: got %h want ffffff", bcd_out); end
            n_checks++;
            if (src !== 2'd0) begin n_errors++; $display("FAIL reset_src: got %0d want 0", src); end
            n_checks++;
            if (scroll_step !== 1'b0) begin n_errors++; $display("FAIL reset_step: got %b want 0", scroll_step); end
        end
        $display("test_reset: idle 10 cycles checked");
    endtask

    task automatic test_banner();
        int steps_seen;
        int done_at;
        int idle_after;
        clear_inputs();
        banner_start = 1'b1;
        cyc();
        banner_start = 1'b0;
        steps_seen = 0;
        done_at    = -1;
        idle_after = -1;
        for (int i = 0; i < 80 && idle_after < 0; i++) begin
            n_checks++;
            if (src !== 2'(m_src)) begin n_errors++; $display("FAIL banner_src: got %0d want %0d", src, m_src); end
            n_checks++;
            if (scroll_pos !== e_pos) begin n_errors++; $display("FAIL banner_pos: got %0d want %0d", scroll_pos, e_pos); end
            n_checks++;
            if (scroll_step !== e_step) begin n_errors++; $display("FAIL banner_step: got %b want %b", scroll_step, e_step); end
            n_checks++;
            if (bcd_out !== m_bcd) begin n_errors++; $display("FAIL banner_bcd: got %h want %h", bcd_out, m_bcd); end
            if (scroll_step === 1'b1) steps_seen++;
            if (banner_done === 1'b1) done_at = steps_seen;
            if (m_src == 0 && done_at >= 0) idle_after = i;
            cyc();
        end
        n_checks++;
        if (done_at !== 16) begin n_errors++; $display("FAIL banner_done_step: got %0d want 16", done_at); end
        n_checks++;
        if (src !== 2'd0) begin n_errors++; $display("FAIL banner_end_src: got %0d want 0", src); end
        n_checks++;
        if (bcd_out !== 24'hFFFFFF) begin n_errors++; $display("FAIL banner_end_bcd: got %h want ffffff", bcd_out); end
        $display("test_banner: steps=%0d done_at_step=%0d", steps_seen, done_at);
    endtask

    task automatic test_timer_preempt();
        logic [23:0] t;
        int i;
        clear_inputs();
        banner_start = 1'b1;
        cyc();
        banner_start = 1'b0;
        for (i = 0; i < 40 && e_pos != 4'd5; i++) cyc();
        n_checks++;
        if (scroll_pos !== 4'd5) begin n_errors++; $display("FAIL preempt_pos: got %0d want 5", scroll_pos); end
        timer_req = 1'b1;
        cyc();
        n_checks++;
        if (src !== 2'd2) begin n_errors++; $display("FAIL preempt_src: got %0d want 2", src); end
        t = timer_bcd;
        cyc();
        n_checks++;
        if (bcd_out !== t) begin n_errors++; $display("FAIL preempt_bcd: got %h want %h", bcd_out, t); end
        timer_req = 1'b0;
        cyc();
        n_checks++;
        if (src !== 2'd0) begin n_errors++; $display("FAIL preempt_release_src: got %0d want 0", src); end
        n_checks++;
        if (scroll_pos !== 4'd0) begin n_errors++; $display("FAIL preempt_release_pos: got %0d want 0", scroll_pos); end
        $display("test_timer_preempt: banner abandoned at pos 5");
    endtask

    task automatic test_hold();
        int c;
        clear_inputs();
        timer_req = 1'b1;
        cyc();
        res_valid = 1'b1;
        res_bcd   = 24'h0F0123;
        cyc();
        res_valid = 1'b0;
        n_checks++;
        if (src !== 2'd3) begin n_errors++; $display("FAIL hold_src: got %0d want 3", src); end
        cyc();
        n_checks++;
        if (bcd_out !== 24'h0F0123) begin n_errors++; $display("FAIL hold_bcd: got %h want 0f0123", bcd_out); end
        c = 1;
        while (src === 2'd3 && c < 30) begin
            cyc();
            c++;
        end
        n_checks++;
        if (c !== HT * TD) begin n_errors++; $display("FAIL hold_len: got %0d want %0d", c, HT * TD); end
        n_checks++;
        if (src !== 2'd2) begin n_errors++; $display("FAIL hold_exit_src: got %0d want 2", src); end
        $display("test_hold: held %0d cycles", c);
    endtask

    task automatic test_hold_retrigger();
        int c;
        clear_inputs();
        cyc();
        cyc();
        res_valid = 1'b1;
        res_bcd   = 24'h111111;
        cyc();
        res_valid = 1'b0;
        repeat (TD) cyc();
        res_valid = 1'b1;
        res_bcd   = 24'h000999;
        cyc();
        res_valid = 1'b0;
        cyc();
        n_checks++;
        if (bcd_out !== 24'h000999) begin n_errors++; $display("FAIL retrig_bcd: got %h want 000999", bcd_out); end
        c = 1;
        while (src === 2'd3 && c < 30) begin
            cyc();
            c++;
        end
        n_checks++;
        if (c !== HT * TD) begin n_errors++; $display("FAIL retrig_len: got %0d want %0d", c, HT * TD); end
        n_checks++;
        if (src !== 2'd0) begin n_errors++; $display("FAIL retrig_exit_src: got %0d want 0", src); end
        $display("test_hold_retrigger: second hold %0d cycles", c);
    endtask

    task automatic test_async_reset();
        int i;
        clear_inputs();
        banner_start = 1'b1;
        cyc();
        banner_start = 1'b0;
        for (i = 0; i < 60 && e_pos != 4'd9; i++) cyc();
        n_checks++;
        if (scroll_pos !== 4'd9) begin n_errors++; $display("FAIL areset_pre_pos: got %0d want 9", scroll_pos); end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (src !== 2'd0) begin n_errors++; $display("FAIL areset_src: got %0d want 0", src); end
        n_checks++;
        if (scroll_pos !== 4'd0) begin n_errors++; $display("FAIL areset_pos: got %0d want 0", scroll_pos); end
        n_checks++;
        if (bcd_out !== 24'hFFFFFF) begin n_errors++; $display("FAIL areset_bcd: got %h want ffffff", bcd_out); end
        n_checks++;
        if (scroll_step !== 1'b0 || banner_done !== 1'b0) begin
            n_errors++; $display("FAIL areset_pulses: got step=%b done=%b want 0 0", scroll_step, banner_done);
        end
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        m_reset();
        for (int k = 0; k < 4 * TD; k++) begin
            cyc();
            n_checks++;
            if (src !== 2'd0 || banner_done !== 1'b0) begin
                n_errors++; $display("FAIL areset_after: got src=%0d done=%b want 0 0", src, banner_done);
            end
        end
        $display("test_async_reset: reset at pos 9, no resume");
    endtask

    task automatic test_random();
        int errs_before;
        errs_before = n_errors;
        clear_inputs();
        for (int i = 0; i < 1500; i++) begin
            banner_start = ($urandom_range(0, 9) == 0);
            res_valid    = ($urandom_range(0, 59) == 0);
            res_bcd      = 24'($urandom);
            if ($urandom_range(0, 39) == 0) timer_req = ~timer_req;
            cyc();
            n_checks++;
            if (src !== 2'(m_src)) begin n_errors++; $display("FAIL rand_src @%0d: got %0d want %0d", i, src, m_src); end
            n_checks++;
            if (scroll_pos !== e_pos) begin n_errors++; $display("FAIL rand_pos @%0d: got %0d want %0d", i, scroll_pos, e_pos); end
            n_checks++;
            if (scroll_step !== e_step) begin n_errors++; $display("FAIL rand_step @%0d: got %b want %b", i, scroll_step, e_step); end
            n_checks++;
            if (banner_done !== e_done) begin n_errors++; $display("FAIL rand_done @%0d: got %b want %b", i, banner_done, e_done); end
            n_checks++;
            if (bcd_out !== m_bcd) begin n_errors++; $display("FAIL rand_bcd @%0d: got %h want %h", i, bcd_out, m_bcd); end
        end
        $display("test_random: 1500 cycles, %0d new errors", n_errors - errs_before);
    endtask

    initial begin
        rst_n      = 1'b0;
        banner_bcd = '0;
        timer_bcd  = '0;
        clear_inputs();
        m_reset();
        test_reset();
        test_banner();
        test_timer_preempt();
        test_hold();
        test_hold_retrigger();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
